seq_divider: RTL and testbench

//  Iterative radix-2 restoring divider: one quotient bit per clock.

---
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider producing one quotient bit per clock, with valid/ready handshakes.
// Define DIV_SIGNED_EN to add two's-complement division selected per operation by signed_op.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   shifted, trial;
  logic             qbit;
  logic [WIDTH-1:0] op_a, op_b, fin_q, fin_r;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      qsh_q   <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      qsh_q   <= qsh_d;
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  // The dividend is shifted out of qsh_q from the top while quotient bits enter at the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    qsh_d   = qsh_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    op_a    = dividend;
    op_b    = divisor;
    shifted = {part_q, qsh_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    qbit    = ~trial[WIDTH];
    fin_q   = {qsh_q[WIDTH-2:0], qbit};
    fin_r   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (signed_op) begin
      if (dividend[WIDTH-1]) op_a = -dividend;
      if (divisor[WIDTH-1])  op_b = -divisor;
    end
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH - 1);
            part_d  = '0;
            qsh_d   = op_a;
            dvsr_d  = op_b;
`ifdef DIV_SIGNED_EN
            neg_q_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_d = signed_op && dividend[WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        part_d = fin_r;
        qsh_d  = fin_q;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          dbz_d   = 1'b0;
          quo_d   = fin_q;
          rem_d   = fin_r;
`ifdef DIV_SIGNED_EN
          // MIN/-1 needs no special case: magnitude quotient MIN stays MIN unnegated.
          if (neg_q_q) quo_d = -fin_q;
          if (neg_r_q) rem_d = -fin_r;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider (WIDTH=8) against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int lat;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Signed results use the language's truncating division directly.
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    z = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s && SIGNED_BUILD) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80;
        r = 8'h00;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic waitResult(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
    logic [W-1:0] eq, er;
    logic         ez;
    int           n, cyc;
    refModel(a, b, s, eq, er, ez);
    out_ready = (hold == 0);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    signed_op = 1'($urandom);
    waitResult(cyc);
    checkOutput("latency", cyc, ez ? 1 : 9);
    checkOutput("quotient", quotient, eq);
    checkOutput("remainder", remainder, er);
    checkOutput("div_by_zero", div_by_zero, ez);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_quotient", quotient, eq);
      checkOutput("hold_remainder", remainder, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_valid", out_valid, 0);
    checkOutput("release_idle", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    signed_op = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(8'd100, 8'd7, 1'b0, 0);
    applyStimulus(8'd55, 8'd0, 1'b0, 0);
    applyStimulus(8'd200, 8'd3, 1'b0, 5);

    // Back-to-back with in_valid held high: second accept right after the first handshake.
    out_ready = 1'b1;
    dividend  = 8'd255;
    divisor   = 8'd1;
    signed_op = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    dividend = 8'd9;
    divisor  = 8'd10;
    waitResult(lat);
    checkOutput("b2b_lat1", lat, 9);
    checkOutput("b2b_q1", quotient, 255);
    checkOutput("b2b_r1", remainder, 0);
    @(posedge clk); #1;
    checkOutput("b2b_idle", in_ready, 1);
    @(posedge clk); #1;
    checkOutput("b2b_accept2", busy, 1);
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput("b2b_lat2", lat, 9);
    checkOutput("b2b_q2", quotient, 0);
    checkOutput("b2b_r2", remainder, 9);
    @(posedge clk); #1;

    // Asynchronous reset three cycles into a calculation.
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_quotient", quotient, 0);
    checkOutput("midreset_remainder", remainder, 0);
    checkOutput("midreset_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'd17, 8'd4, 1'b0, 0);

    applyStimulus(8'hF9, 8'h02, 1'b1, 0);
    applyStimulus(8'h07, 8'hFE, 1'b1, 0);
    applyStimulus(8'h80, 8'hFF, 1'b1, 0);
    applyStimulus(8'h80, 8'h00, 1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      applyStimulus(W'($urandom),
                    ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom),
                    1'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
